// File: rtl/tiro_inimigo_pkg.sv
// Shared definitions for the enemy-shot block: FSM encodings, sprite sizes
// (also used by the row, enemy and renderer blocks) and the LFSR step.
package tiro_inimigo_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    ESCOLHA = 2'd1,
    VOO     = 2'd2,
    ACERTO  = 2'd3
  } estado_t;

  localparam int INIM_W = 33;
  localparam int INIM_H = 24;
  localparam int TIRO_W = 4;
  localparam int TIRO_H = 8;
  localparam int NAVE_W = 33;
  localparam int NAVE_H = 16;

  // Right-shifting Galois form of x^8+x^6+x^5+x^4+1
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_passo(input logic [7:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/tiro_inimigo_colisao_ret.sv
// Combinational axis-aligned rectangle overlap on 11-bit coordinates;
// shared with the ship/ball collision logic.
module colisao_ret (
  input  logic [10:0] a_x_i,
  input  logic [10:0] a_y_i,
  input  logic [10:0] a_w_i,
  input  logic [10:0] a_h_i,
  input  logic [10:0] b_x_i,
  input  logic [10:0] b_y_i,
  input  logic [10:0] b_w_i,
  input  logic [10:0] b_h_i,
  output logic        sobrepoe_o
);

  assign sobrepoe_o = (a_x_i < b_x_i + b_w_i) && (b_x_i < a_x_i + a_w_i) &&
                      (a_y_i < b_y_i + b_h_i) && (b_y_i < a_y_i + a_h_i);

endmodule

// File: rtl/tiro_inimigo.sv
// Enemy-shot controller: periodically picks an alive enemy, drops one bullet
// and strobes acerto_nave on ship hit. TIRO_MIRADO_EN selects aimed targeting.
module tiro_inimigo
  import tiro_inimigo_pkg::*;
#(
  parameter int         N_INIM  = 5,
  parameter int         PERIODO = 16,
  parameter int         VEL     = 4,
  parameter int         TELA_H  = 480,
  parameter logic [7:0] SEMENTE = 8'hA5
) (
  input  logic                CLOCK_50,
  input  logic                reset,
  input  logic                reiniciarJogo,
  input  logic                pausa,
  input  logic                tick_mv,
  input  logic [N_INIM*10-1:0] inimigo_x,
  input  logic [N_INIM*10-1:0] inimigo_y,
  input  logic [N_INIM-1:0]   vivo,
  input  logic [9:0]          nave_x,
  input  logic [9:0]          nave_y,
  output logic [9:0]          tiro_x,
  output logic [9:0]          tiro_y,
  output logic                tiro_ativo,
  output logic                acerto_nave
);

  localparam int         CD_W   = (PERIODO > 2) ? $clog2(PERIODO) : 1;
  localparam logic [CD_W-1:0] CD_MAX = CD_W'(PERIODO - 1);
  localparam logic [2:0] ULTIMO = 3'(N_INIM - 1);

  estado_t          estado_q, estado_d;
  logic [CD_W-1:0]  cd_q, cd_d;
  logic [2:0]       idx_q, idx_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [7:0]       lfsr_q;
  logic [9:0]       tx_q, tx_d, ty_q, ty_d;
  logic             ativo_q, ativo_d;
  logic             acerto_q, acerto_d;

  logic             rst;
  logic [9:0]       pos_x [8];
  logic [9:0]       pos_y [8];
  logic [7:0]       vivo8;
  logic [10:0]      ny_soma;
  logic             acerta;
  logic             lanca;
  logic [2:0]       k_lanc;

  assign rst = reset | reiniciarJogo;

  always_comb begin
    vivo8 = '0;
    vivo8[N_INIM-1:0] = vivo;
    for (int k = 0; k < 8; k++) begin
      pos_x[k] = '0;
      pos_y[k] = '0;
    end
    for (int k = 0; k < N_INIM; k++) begin
      pos_x[k] = inimigo_x[k*10 +: 10];
      pos_y[k] = inimigo_y[k*10 +: 10];
    end
  end

  // Candidate position after this tick, widened so it cannot wrap
  assign ny_soma = {1'b0, ty_q} + 11'(VEL);

  colisao_ret u_colisao (
    .a_x_i      ({1'b0, tx_q}),
    .a_y_i      (ny_soma),
    .a_w_i      (11'(TIRO_W)),
    .a_h_i      (11'(TIRO_H)),
    .b_x_i      ({1'b0, nave_x}),
    .b_y_i      ({1'b0, nave_y}),
    .b_w_i      (11'(NAVE_W)),
    .b_h_i      (11'(NAVE_H)),
    .sobrepoe_o (acerta)
  );

`ifdef TIRO_MIRADO_EN
  logic [11:0] centro_i, centro_n, dist;
  logic [11:0] best_dist_q, best_dist_d;
  logic [2:0]  best_q, best_d;
  logic        best_ok_q, best_ok_d;
  logic        cand;

  always_comb begin
    centro_i = {2'b0, pos_x[idx_q]} + 12'(INIM_W / 2);
    centro_n = {2'b0, nave_x} + 12'(NAVE_W / 2);
    dist     = (centro_i >= centro_n) ? (centro_i - centro_n) : (centro_n - centro_i);
    // Strict less-than keeps the lowest index on ties
    cand     = vivo8[idx_q] && (!best_ok_q || (dist < best_dist_q));
  end

  assign k_lanc = cand ? idx_q : best_q;
`else
  logic [2:0] idx_ini;

  assign idx_ini = (lfsr_q[2:0] >= 3'(N_INIM)) ? (lfsr_q[2:0] - 3'(N_INIM)) : lfsr_q[2:0];
  assign k_lanc  = idx_q;
`endif

  always_comb begin
    estado_d = estado_q;
    cd_d     = cd_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    tx_d     = tx_q;
    ty_d     = ty_q;
    ativo_d  = ativo_q;
    acerto_d = 1'b0;
    lanca    = 1'b0;
`ifdef TIRO_MIRADO_EN
    best_d      = best_q;
    best_ok_d   = best_ok_q;
    best_dist_d = best_dist_q;
`endif
    if (!pausa) begin
      case (estado_q)
        OCIOSO: begin
          if (tick_mv) begin
            if (cd_q != CD_MAX) begin
              cd_d = cd_q + 1'b1;
            end else if (|vivo) begin
              cd_d     = '0;
              estado_d = ESCOLHA;
              cnt_d    = '0;
`ifdef TIRO_MIRADO_EN
              idx_d     = '0;
              best_ok_d = 1'b0;
`else
              idx_d = idx_ini;
`endif
            end
          end
        end
        ESCOLHA: begin
`ifdef TIRO_MIRADO_EN
          if (cnt_q == ULTIMO) begin
            if (cand || best_ok_q) lanca = 1'b1;
            else                   estado_d = OCIOSO;
          end else begin
            cnt_d = cnt_q + 3'd1;
            idx_d = idx_q + 3'd1;
            if (cand) begin
              best_d      = idx_q;
              best_ok_d   = 1'b1;
              best_dist_d = dist;
            end
          end
`else
          if (vivo8[idx_q]) begin
            lanca = 1'b1;
          end else if (cnt_q == ULTIMO) begin
            estado_d = OCIOSO;
          end else begin
            cnt_d = cnt_q + 3'd1;
            idx_d = (idx_q == ULTIMO) ? 3'd0 : (idx_q + 3'd1);
          end
`endif
        end
        VOO: begin
          if (tick_mv) begin
            if (acerta) begin
              estado_d = ACERTO;
              ativo_d  = 1'b0;
              acerto_d = 1'b1;
            end else if (ny_soma >= 11'(TELA_H)) begin
              estado_d = OCIOSO;
              ativo_d  = 1'b0;
            end else begin
              ty_d = ny_soma[9:0];
            end
          end
        end
        ACERTO: estado_d = OCIOSO;
        default: estado_d = OCIOSO;
      endcase
    end
    if (lanca) begin
      tx_d     = pos_x[k_lanc] + 10'((INIM_W - TIRO_W) / 2);
      ty_d     = pos_y[k_lanc] + 10'(INIM_H);
      ativo_d  = 1'b1;
      estado_d = VOO;
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      estado_q <= OCIOSO;
      cd_q     <= '0;
      idx_q    <= '0;
      cnt_q    <= '0;
      lfsr_q   <= SEMENTE;
      tx_q     <= '0;
      ty_q     <= '0;
      ativo_q  <= 1'b0;
      acerto_q <= 1'b0;
    end else begin
      estado_q <= estado_d;
      cd_q     <= cd_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      lfsr_q   <= lfsr_passo(lfsr_q);
      tx_q     <= tx_d;
      ty_q     <= ty_d;
      ativo_q  <= ativo_d;
      acerto_q <= acerto_d;
    end
  end

`ifdef TIRO_MIRADO_EN
  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      best_q      <= '0;
      best_ok_q   <= 1'b0;
      best_dist_q <= '0;
    end else begin
      best_q      <= best_d;
      best_ok_q   <= best_ok_d;
      best_dist_q <= best_dist_d;
    end
  end
`endif

  assign tiro_x      = tx_q;
  assign tiro_y      = ty_q;
  assign tiro_ativo  = ativo_q;
  assign acerto_nave = acerto_q;

endmodule
